// File: rtl/ds_pkg.sv
// Shared types and constants for the delta-sigma sample scheduler.
package ds_pkg;

  localparam int SAMPLE_BITS = 16;
  localparam int MIDSCALE    = 1 << (SAMPLE_BITS - 1);

  typedef logic [SAMPLE_BITS-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output. Pointers wrap modulo depth and
// occupancy is kept in its own counter so full/empty need no extra pointer bit.
module sync_fifo
  import ds_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_BITS,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  do_push, do_pop;

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (level_q == DEPTH_LVL);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ds_sample_scheduler.sv
// Feeds buffered samples to the modulator u input, one pop every
// (rate_div+1) modulator pulses, with sticky underrun reporting.
module ds_sample_scheduler #(
  parameter int SAMPLE_BITS     = 16,
  parameter int FIFO_DEPTH_LOG2 = 3,
  parameter int DIV_BITS        = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [SAMPLE_BITS-1:0]     wr_data,
  output logic                       wr_ready,
  input  logic                       enable,
  input  logic [DIV_BITS-1:0]        rate_div,
  input  logic                       hold_mode,
  input  logic                       pulse_done,
  output logic [SAMPLE_BITS-1:0]     u_out,
  output logic                       u_update,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       underrun,
  input  logic                       clr_underrun
);

  import ds_pkg::*;

  localparam logic [SAMPLE_BITS-1:0] MID_U = SAMPLE_BITS'(1) << (SAMPLE_BITS - 1);

  logic [DIV_BITS-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] u_out_q, u_out_d;
  logic                   u_update_q, u_update_d;
  logic                   underrun_q, underrun_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [SAMPLE_BITS-1:0] fifo_dout;
  logic                   pop_slot;

  assign wr_ready  = !fifo_full;
  assign fifo_push = wr_valid && wr_ready;
  // Slot fires on the pulse where the down-counter has reached zero, so the
  // first pulse after enable rises always pops.
  assign pop_slot  = enable && pulse_done && (cnt_q == '0);
  // Emptiness is registered, so a same-cycle push into an empty FIFO is not
  // visible to this slot; it is picked up at the next one.
  assign fifo_pop  = pop_slot && !fifo_empty;

  sync_fifo #(
    .WIDTH      (SAMPLE_BITS),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pulse divider, u register, update strobe and sticky underrun next-state.
  always_comb begin
    cnt_d      = cnt_q;
    u_out_d    = u_out_q;
    u_update_d = 1'b0;
    underrun_d = underrun_q;

    if (!enable) begin
      cnt_d = '0;
    end else if (pulse_done) begin
      // rate_div is sampled only at reload, so mid-count changes wait.
      cnt_d = (cnt_q == '0) ? rate_div : cnt_q - DIV_BITS'(1);
    end

    if (pop_slot && !fifo_empty) begin
      u_out_d    = fifo_dout;
      u_update_d = 1'b1;
    end else if (pop_slot && !hold_mode) begin
      u_out_d = MID_U;
    end

    // A same-cycle set beats the clear.
    if (pop_slot && fifo_empty) underrun_d = 1'b1;
    else if (clr_underrun)      underrun_d = 1'b0;
  end

  // Scheduler registers; reset restores midscale and clears all status.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      u_out_q    <= MID_U;
      u_update_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      u_out_q    <= u_out_d;
      u_update_q <= u_update_d;
      underrun_q <= underrun_d;
    end
  end

  assign u_out    = u_out_q;
  assign u_update = u_update_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_ds_sample_scheduler.sv
// Bench for ds_sample_scheduler: directed scenarios then random traffic,
// all checked against a queue-based reference model and a pop scoreboard.
module tb_ds_sample_scheduler;

  logic        clk = 1'b0;
  logic        reset, wr_valid, enable, hold_mode, pulse_done, clr_underrun;
  logic [15:0] wr_data;
  logic [7:0]  rate_div;
  logic        wr_ready, u_update, underrun;
  logic [15:0] u_out;
  logic [3:0]  fifo_level;

  always #5 clk = ~clk;

  ds_sample_scheduler #(
    .SAMPLE_BITS     (16),
    .FIFO_DEPTH_LOG2 (3),
    .DIV_BITS        (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .enable       (enable),
    .rate_div     (rate_div),
    .hold_mode    (hold_mode),
    .pulse_done   (pulse_done),
    .u_out        (u_out),
    .u_update     (u_update),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .clr_underrun (clr_underrun)
  );

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] exp_q[$];
  int          m_cnt;
  logic [15:0] m_u;
  bit          m_und, m_upd;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one call per clock edge using the inputs held at that edge.
  task automatic model_step();
    bit slot, was_empty, was_full;
    if (reset) begin
      mq.delete();
      m_cnt = 0;
      m_u   = 16'h8000;
      m_und = 0;
      m_upd = 0;
      return;
    end
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == 8);
    slot      = enable && pulse_done && (m_cnt == 0);
    m_upd     = 0;
    if (slot && !was_empty) begin
      m_u   = mq.pop_front();
      m_upd = 1;
      exp_q.push_back(m_u);
    end else if (slot) begin
      if (!hold_mode) m_u = 16'h8000;
    end
    if (slot && was_empty) m_und = 1;
    else if (clr_underrun) m_und = 0;
    if (wr_valid && !was_full) mq.push_back(wr_data);
    if (!enable) m_cnt = 0;
    else if (pulse_done) m_cnt = (m_cnt == 0) ? int'(rate_div) : m_cnt - 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    mon_on = 1;
    #1;
  endtask

  task automatic pulse(input int gap);
    pulse_done = 1;
    tick();
    pulse_done = 0;
    repeat (gap - 1) tick();
  endtask

  task automatic push(input logic [15:0] d);
    wr_valid = 1;
    wr_data  = d;
    tick();
    wr_valid = 0;
  endtask

  // Monitor: compares DUT state to the model and drains the pop scoreboard.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("u_out", u_out, m_u);
      chk("fifo_level", fifo_level, mq.size());
      chk("wr_ready", wr_ready, (mq.size() != 8));
      chk("underrun", underrun, m_und);
      chk("u_update", u_update, m_upd);
      if (u_update) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_scoreboard: got u_update with u_out %0h, required no pop", u_out);
        end else begin
          chk("pop_value", u_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1; wr_valid = 0; wr_data = 0; enable = 0; rate_div = 0;
    hold_mode = 0; pulse_done = 0; clr_underrun = 0;
    repeat (3) tick();
    reset = 0;

    // Reset state with no stimulus
    repeat (3) tick();
    chk("t1_u_out", u_out, 16'h8000);
    chk("t1_u_update", u_update, 0);
    chk("t1_level", fifo_level, 0);
    chk("t1_wr_ready", wr_ready, 1);
    chk("t1_underrun", underrun, 0);

    // Prefill while disabled, then one dropped push
    for (int i = 1; i <= 7; i++) push(16'(i * 16'h1000));
    push(16'h7FFF);
    chk("t2_level_full", fifo_level, 8);
    chk("t2_wr_ready", wr_ready, 0);
    push(16'hABCD);
    chk("t2_level_after_drop", fifo_level, 8);

    // Paced pops every third pulse
    rate_div = 2;
    enable   = 1;
    tick();
    pulse_done = 1;
    tick();
    pulse_done = 0;
    chk("t3_first_pop", u_out, 16'h1000);
    chk("t3_first_update", u_update, 1);
    repeat (9) tick();
    for (int p = 2; p <= 22; p++) pulse(10);
    chk("t3_drained", fifo_level, 0);
    chk("t3_last", u_out, 16'h7FFF);

    // Underrun with hold, then with midscale
    rate_div  = 0;
    hold_mode = 1;
    repeat (3) pulse(4);
    chk("t4_underrun", underrun, 1);
    chk("t4_hold", u_out, 16'h7FFF);
    hold_mode = 0;
    pulse(4);
    chk("t4_midscale", u_out, 16'h8000);

    // Clear versus same-cycle set
    clr_underrun = 1;
    tick();
    chk("t5_cleared", underrun, 0);
    pulse_done = 1;
    tick();
    pulse_done = 0;
    chk("t5_set_wins", underrun, 1);
    tick();
    chk("t5_clear_later", underrun, 0);
    clr_underrun = 0;

    // Reset mid-operation
    enable = 0;
    for (int i = 0; i < 6; i++) push(16'($urandom_range(0, 16'hFFFF)));
    rate_div = 3;
    enable   = 1;
    pulse(3);
    pulse(3);
    chk("t6_pre_level", fifo_level, 5);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_level", fifo_level, 0);
    chk("t6_u_out", u_out, 16'h8000);
    chk("t6_underrun", underrun, 0);
    pulse(2);
    chk("t6_needs_data", underrun, 1);
    chk("t6_no_update", u_update, 0);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      wr_valid     = ($urandom_range(0, 2) == 0);
      wr_data      = 16'($urandom);
      pulse_done   = ($urandom_range(0, 3) == 0);
      enable       = ($urandom_range(0, 15) != 0);
      hold_mode    = 1'($urandom);
      clr_underrun = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 63) == 0) rate_div = 8'($urandom_range(0, 3));
      reset        = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 0; wr_valid = 0; pulse_done = 0; clr_underrun = 0;
    tick();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
